// File: rtl/dec3to8_clk_unit_if.sv
// dec3to8_clk_unit_if: decoder select bus plus buffered/divided clock outputs
interface dec3to8_clk_unit_if;
  logic E;
  logic [2:0] In;
  logic [7:0] Out;
  logic clka_out;
  logic clkb_out;
  modport master (output E, In, input Out, clka_out, clkb_out);
  modport slave (input E, In, output Out, clka_out, clkb_out);
endinterface

// File: rtl/dec3to8_clk_unit.sv
// dec3to8_clk_unit: enable-gated 3-to-8 decoder, clka buffer and clka/DIV_B divider; DECODER_REG_OUT_EN registers Out
module dec3to8_clk_unit #(
  parameter int DIV_B = 2
) (
  input logic clka,
  input logic rst,
  dec3to8_clk_unit_if.slave bus
);
  localparam int HALF = DIV_B / 2;
  localparam int CW = $clog2(HALF) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);
  logic [CW-1:0] cnt;
  logic clkb;
  logic [7:0] dec;
  assign dec = bus.E ? 8'h01 << bus.In : 8'h00;
  assign bus.clka_out = clka;
  assign bus.clkb_out = clkb;
  // clkb toggles once every HALF rising edges, giving a 50% duty clka/DIV_B
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      clkb <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      clkb <= ~clkb;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`ifdef DECODER_REG_OUT_EN
  always_ff @(posedge clka or posedge rst) begin
    if (rst) bus.Out <= 8'h00;
    else bus.Out <= dec;
  end
`else
  assign bus.Out = dec;
`endif
endmodule

// File: tb/tb_dec3to8_clk_unit.sv
// tb_dec3to8_clk_unit: directed and random checks of decoder, clock buffer and divider (DIV_B=2 and 6)
module tb_dec3to8_clk_unit;
  logic clka = 1'b0;
  logic rst = 1'b1;
  logic e = 1'b0;
  logic [2:0] in_sel = 3'd0;
  int total = 0;
  int bad = 0;
  int n = 0;
  logic [7:0] last = 8'h00;
  logic found;
  dec3to8_clk_unit_if b2 ();
  dec3to8_clk_unit_if b6 ();
  assign b2.E = e;
  assign b2.In = in_sel;
  assign b6.E = e;
  assign b6.In = in_sel;
  dec3to8_clk_unit #(.DIV_B(2)) u2 (.clka(clka), .rst(rst), .bus(b2.slave));
  dec3to8_clk_unit #(.DIV_B(6)) u6 (.clka(clka), .rst(rst), .bus(b6.slave));
  always #10 clka = ~clka;
  function automatic logic [7:0] dec(logic en, logic [2:0] s);
    return en ? 8'(2 ** int'(s)) : 8'h00;
  endfunction
  // reference: rising edges since reset, and the decode captured at the latest edge
  always @(posedge clka or posedge rst) begin
    if (rst) begin
      n = 0;
      last = 8'h00;
    end else begin
      n++;
      last = dec(e, in_sel);
    end
  end
  function logic [7:0] exp_out();
`ifdef DECODER_REG_OUT_EN
    return rst ? 8'h00 : last;
`else
    return dec(e, in_sel);
`endif
  endfunction
  function logic exp_clkb(int half);
    return rst ? 1'b0 : 1'((n / half) % 2);
  endfunction
  task automatic check(string tag, logic [7:0] o, logic [7:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask
  task automatic check_all(string tag);
    check({tag, "_out2"}, b2.Out, exp_out());
    check({tag, "_out6"}, b6.Out, exp_out());
    check({tag, "_clkb2"}, {7'd0, b2.clkb_out}, {7'd0, exp_clkb(1)});
    check({tag, "_clkb6"}, {7'd0, b6.clkb_out}, {7'd0, exp_clkb(3)});
    check({tag, "_clka_out"}, {7'd0, b2.clka_out}, {7'd0, clka});
  endtask
  initial begin
    repeat (2) @(negedge clka);
    check_all("reset");
    in_sel = 3'b101;
    #1 check_all("reset_e0_in5");
    @(negedge clka);
    rst = 1'b0;
    #1 check_all("release");
    @(negedge clka);
    in_sel = 3'b000;
    #1 check_all("e0_in0");
    @(posedge clka);
    #1 check_all("e0_in0_edge");
    @(negedge clka);
    in_sel = 3'b101;
    #1 check_all("e0_in5");
    @(posedge clka);
    #1 check_all("e0_in5_edge");
    for (int i = 0; i < 8; i++) begin
      @(negedge clka);
      e = 1'b1;
      in_sel = 3'(i);
      #1 check_all("sweep");
      @(posedge clka);
      #1 check_all("sweep_edge");
    end
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clka);
      if (exp_clkb(3)) found = 1'b1;
    end
    check("find_clkb6_high", {7'd0, b6.clkb_out}, 8'd1);
    #3 rst = 1'b1;
    #1 check_all("rst_mid_high");
    #2 rst = 1'b0;
    repeat (14) begin
      @(negedge clka);
      #1 check_all("resume");
    end
    repeat (200) begin
      @(negedge clka);
      e = 1'($urandom);
      in_sel = 3'($urandom);
      #1 check_all("rand");
      if ($urandom_range(0, 15) == 0) begin
        #2 rst = 1'b1;
        #1 check_all("rand_rst");
        #2 rst = 1'b0;
      end
      @(posedge clka);
      #1 check_all("rand_edge");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
